// File: rtl/mul24_pkg.sv
// Shared constants and state encoding for the sequential 24x24 multiplier.
package mul24_pkg;

  localparam int WIDTH = 24;
  localparam int CNT_W = 5;
  localparam logic [CNT_W-1:0] LAST_CNT = 5'd23;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/mul24_seq_if.sv
// Operand/result handshake bundle for mul24_seq; slave is the multiplier side.
interface mul24_seq_if;
  import mul24_pkg::*;

  logic                 in_valid;
  logic                 in_ready;
  logic [WIDTH-1:0]     a;
  logic [WIDTH-1:0]     b;
  logic                 out_valid;
  logic                 out_ready;
  logic [2*WIDTH-1:0]   product;
  logic                 busy;

  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, product, busy
  );

  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, product, busy
  );

endinterface

// File: rtl/mul24_seq_adder.sv
// 24-bit ripple-carry adder shared with the execute stage; carry-in is tied to zero.
module Mbledhesi24bit (
  input  logic [23:0] A,
  input  logic [23:0] B,
  output logic [23:0] Sum,
  output logic        CarryOut
);

  always_comb begin : ripple
    logic cy;
    Sum = '0;
    cy  = 1'b0;
    for (int i = 0; i < 24; i++) begin
      Sum[i] = A[i] ^ B[i] ^ cy;
      cy     = (A[i] & B[i]) | (cy & (A[i] ^ B[i]));
    end
    CarryOut = cy;
  end

endmodule

// File: rtl/mul24_seq.sv
// Sequential 24x24 unsigned shift-and-add multiplier, one partial-product add per cycle.
// Optional build macro MUL24_EARLY_EXIT_EN: zero operands finish in one cycle without RUN work.
//
// state | meaning
// IDLE  | in_ready=1, waiting for operands
// RUN   | one add/shift per edge, count 0..23
// DONE  | out_valid=1, product held until out_ready
module mul24_seq
  import mul24_pkg::*;
#(
  parameter int WIDTH = mul24_pkg::WIDTH
) (
  input  logic      clk,
  input  logic      rst_n,
  mul24_seq_if.slave bus
);

  state_t               state;
  logic [CNT_W-1:0]     count;
  logic [2*WIDTH-1:0]   p;
  logic [WIDTH-1:0]     mcand;
  logic [WIDTH-1:0]     add_b;
  logic [WIDTH-1:0]     sum;
  logic                 carry;
  logic                 skip;
  logic                 in_ready_q;
  logic                 out_valid_q;
  logic                 busy_q;

  assign add_b = p[0] ? mcand : '0;

  Mbledhesi24bit u_add (
    .A        (p[2*WIDTH-1:WIDTH]),
    .B        (add_b),
    .Sum      (sum),
    .CarryOut (carry)
  );

`ifdef MUL24_EARLY_EXIT_EN
  assign skip = (bus.a == '0) || (bus.b == '0);
`else
  assign skip = 1'b0;
`endif

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.busy      = busy_q;
  assign bus.product   = p;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      count       <= '0;
      p           <= '0;
      mcand       <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          in_ready_q <= 1'b1;
          if (bus.in_valid && in_ready_q) begin
            mcand      <= bus.a;
            state      <= RUN;
            in_ready_q <= 1'b0;
            // A skipped op parks on the last count with P=0, so the next edge lands in DONE with 0.
            if (skip) begin
              p      <= '0;
              count  <= LAST_CNT;
              busy_q <= 1'b0;
            end else begin
              p      <= {{WIDTH{1'b0}}, bus.b};
              count  <= '0;
              busy_q <= 1'b1;
            end
          end
        end
        RUN: begin
          p     <= {carry, sum, p[WIDTH-1:1]};
          count <= count + 1'b1;
          if (count == LAST_CNT) begin
            state       <= DONE;
            busy_q      <= 1'b0;
            out_valid_q <= 1'b1;
          end
        end
        DONE: begin
          // in_ready rises only after this edge, so there is no same-cycle re-accept.
          if (bus.out_ready) begin
            state       <= IDLE;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
          end
        end
        default: begin
          state       <= IDLE;
          in_ready_q  <= 1'b0;
          out_valid_q <= 1'b0;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mul24_seq.sv
// Scoreboard bench for mul24_seq: expected products queued at issue, popped at result.
module tb_mul24_seq;

`ifdef MUL24_EARLY_EXIT_EN
  localparam int ZERO_LAT  = 1;
  localparam bit ZERO_BUSY = 1'b0;
`else
  localparam int ZERO_LAT  = 24;
  localparam bit ZERO_BUSY = 1'b1;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   pass_cnt = 0;
  int   total_cnt = 0;
  logic [47:0] exp_q[$];

  mul24_seq_if bus();

  mul24_seq dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #3_000_000;
    $display("FAIL watchdog time limit expired");
    $fatal(1);
  end

  // Issue one op, wait for out_valid; returns latency, product, busy seen after accept, timeout flag.
  task automatic run_op(input logic [23:0] a, input logic [23:0] b,
                        output int lat, output logic [47:0] prod,
                        output logic busy_seen, output bit to);
    int n;
    to = 1'b0;
    n = 0;
    while (bus.in_ready !== 1'b1 && n < 60) begin
      @(posedge clk); #1; n++;
    end
    if (bus.in_ready !== 1'b1) to = 1'b1;
    bus.in_valid = 1'b1;
    bus.a = a;
    bus.b = b;
    exp_q.push_back({24'b0, a} * {24'b0, b});
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.a = 24'($urandom);
    bus.b = 24'($urandom);
    busy_seen = bus.busy;
    lat = 0;
    while (bus.out_valid !== 1'b1 && lat < 100) begin
      @(posedge clk); #1; lat++;
    end
    if (bus.out_valid !== 1'b1) to = 1'b1;
    prod = bus.product;
  endtask

  task automatic consume();
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    bus.a = '0;
    bus.b = '0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    total_cnt++;
    if (bus.out_valid !== 1'b0) $display("FAIL reset_out_valid got=%b want=0", bus.out_valid); else pass_cnt++;
    total_cnt++;
    if (bus.busy !== 1'b0) $display("FAIL reset_busy got=%b want=0", bus.busy); else pass_cnt++;
    total_cnt++;
    if (bus.product !== 48'h0) $display("FAIL reset_product got=%h want=0", bus.product); else pass_cnt++;
    rst_n = 1'b1;
    @(posedge clk); #1;
    total_cnt++;
    if (bus.in_ready !== 1'b1) $display("FAIL reset_in_ready got=%b want=1", bus.in_ready); else pass_cnt++;
  endtask

  task automatic test_basic();
    int lat; logic [47:0] prod, exp; logic bs; bit to;
    run_op(24'd5, 24'd5, lat, prod, bs, to);
    exp = exp_q.pop_front();
    total_cnt++;
    if (to) $display("FAIL basic_timeout got=1 want=0"); else pass_cnt++;
    total_cnt++;
    if (lat !== 24) $display("FAIL basic_latency got=%0d want=24", lat); else pass_cnt++;
    total_cnt++;
    if (prod !== exp || prod !== 48'h000000000019) $display("FAIL basic_product got=%h want=%h", prod, exp); else pass_cnt++;
    total_cnt++;
    if (bs !== 1'b1) $display("FAIL basic_busy got=%b want=1", bs); else pass_cnt++;
    consume();
    total_cnt++;
    if (bus.out_valid !== 1'b0) $display("FAIL basic_release got=%b want=0", bus.out_valid); else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    logic [23:0] av[2] = '{24'd6, 24'd205};
    logic [23:0] bv[2] = '{24'd3, 24'd192};
    int lat; logic [47:0] prod, exp; logic bs; bit to;
    for (int i = 0; i < 2; i++) begin
      run_op(av[i], bv[i], lat, prod, bs, to);
      exp = exp_q.pop_front();
      total_cnt++;
      if (to || lat !== 24) $display("FAIL b2b_latency[%0d] got=%0d want=24", i, lat); else pass_cnt++;
      total_cnt++;
      if (prod !== exp) $display("FAIL b2b_product[%0d] got=%h want=%h", i, prod, exp); else pass_cnt++;
      total_cnt++;
      if (bus.in_ready !== 1'b0) $display("FAIL b2b_in_ready_done[%0d] got=%b want=0", i, bus.in_ready); else pass_cnt++;
      bus.in_valid = 1'b1;
      bus.a = 24'd1;
      bus.b = 24'd1;
      consume();
      bus.in_valid = 1'b0;
      total_cnt++;
      if (bus.in_ready !== 1'b1 || bus.busy !== 1'b0)
        $display("FAIL b2b_no_same_cycle_accept[%0d] got=%b%b want=10", i, bus.in_ready, bus.busy);
      else pass_cnt++;
    end
  endtask

  task automatic test_max();
    int lat; logic [47:0] prod, exp; logic bs; bit to;
    run_op(24'hFFFFFF, 24'hFFFFFF, lat, prod, bs, to);
    exp = exp_q.pop_front();
    total_cnt++;
    if (to || lat !== 24) $display("FAIL max_latency got=%0d want=24", lat); else pass_cnt++;
    total_cnt++;
    if (prod !== exp || prod !== 48'hFFFFFE000001) $display("FAIL max_product got=%h want=%h", prod, exp); else pass_cnt++;
    consume();
  endtask

  task automatic test_backpressure();
    int lat; logic [47:0] prod, exp; logic bs; bit to;
    run_op(24'd756, 24'd862, lat, prod, bs, to);
    exp = exp_q.pop_front();
    total_cnt++;
    if (to || prod !== exp || prod !== 48'd651672) $display("FAIL bp_product got=%h want=%h", prod, exp); else pass_cnt++;
    bus.in_valid = 1'b1;
    bus.a = 24'd3;
    bus.b = 24'd4;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      total_cnt++;
      if (bus.out_valid !== 1'b1 || bus.product !== exp || bus.in_ready !== 1'b0)
        $display("FAIL bp_hold[%0d] got=%b/%h/%b want=1/%h/0", i, bus.out_valid, bus.product, bus.in_ready, exp);
      else pass_cnt++;
    end
    bus.in_valid = 1'b0;
    consume();
    repeat (3) @(posedge clk);
    #1;
    total_cnt++;
    if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0 || bus.in_ready !== 1'b1)
      $display("FAIL bp_ignored_op got=%b%b%b want=001", bus.out_valid, bus.busy, bus.in_ready);
    else pass_cnt++;
  endtask

  task automatic test_reset_abort();
    int lat; logic [47:0] prod, exp; logic bs; bit to;
    bit stale;
    bus.in_valid = 1'b1;
    bus.a = 24'd11;
    bus.b = 24'd13;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    total_cnt++;
    if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0 || bus.product !== 48'h0)
      $display("FAIL abort_reset got=%b%b/%h want=00/0", bus.out_valid, bus.busy, bus.product);
    else pass_cnt++;
    rst_n = 1'b1;
    stale = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk); #1;
      if (bus.out_valid !== 1'b0) stale = 1'b1;
    end
    total_cnt++;
    if (stale) $display("FAIL abort_stale_output got=1 want=0"); else pass_cnt++;
    run_op(24'd7, 24'd9, lat, prod, bs, to);
    exp = exp_q.pop_front();
    total_cnt++;
    if (to || lat !== 24) $display("FAIL abort_latency got=%0d want=24", lat); else pass_cnt++;
    total_cnt++;
    if (prod !== exp || prod !== 48'd63) $display("FAIL abort_product got=%h want=%h", prod, exp); else pass_cnt++;
    consume();
  endtask

  task automatic test_zero();
    int lat; logic [47:0] prod, exp; logic bs; bit to;
    run_op(24'd0, 24'd756, lat, prod, bs, to);
    exp = exp_q.pop_front();
    total_cnt++;
    if (to || lat !== ZERO_LAT) $display("FAIL zero_latency got=%0d want=%0d", lat, ZERO_LAT); else pass_cnt++;
    total_cnt++;
    if (prod !== exp || prod !== 48'h0) $display("FAIL zero_product got=%h want=%h", prod, exp); else pass_cnt++;
    total_cnt++;
    if (bs !== ZERO_BUSY) $display("FAIL zero_busy got=%b want=%b", bs, ZERO_BUSY); else pass_cnt++;
    consume();
    total_cnt++;
    if (exp_q.size() !== 0) $display("FAIL scoreboard_leftover got=%0d want=0", exp_q.size()); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_max();
    test_backpressure();
    test_reset_abort();
    test_zero();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
